// File: rtl/regfile_dump_uart.sv
// Register-file debug dumper: snapshots x0..x(NUM_REGS-1) one at a time and
// streams a sync byte followed by each register (MSB byte first) as UART 8N1.
module regfile_dump_uart #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned NUM_REGS     = 32,
    localparam int unsigned ADDR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    output logic [ADDR_W-1:0] DumpAddr,
    input  logic [31:0]       DumpData,
    output logic              TX,
    output logic              BUSY,
    output logic              DONE
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [1:0] B_START = 2'd0;
    localparam logic [1:0] B_DATA  = 2'd1;
    localparam logic [1:0] B_STOP  = 2'd2;

    logic [2:0]        state,    stateNxt;
    logic [1:0]        bitPhase, bitPhaseNxt;
    logic [BAUD_W-1:0] baudCnt,  baudCntNxt;
    logic [2:0]        bitCnt,   bitCntNxt;
    logic [1:0]        byteCnt,  byteCntNxt;
    logic [ADDR_W-1:0] addrNxt;
    logic [31:0]       shadow,   shadowNxt;
    logic              txNxt;
    logic              busyNxt;
    logic              doneNxt;

    logic [7:0] curByte;
    logic       baudLast;
    logic       baudPreLast;
    logic       lastReg;
    logic       loadNext;

    // Byte currently on the wire: sync header, or one shadow byte MSB first
    always_comb begin
        curByte = SYNC_BYTE;
        if (state == S_SEND) begin
            case (byteCnt)
                2'd0:    curByte = shadow[31:24];
                2'd1:    curByte = shadow[23:16];
                2'd2:    curByte = shadow[15:8];
                default: curByte = shadow[7:0];
            endcase
        end
    end

    assign baudLast    = (baudCnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign baudPreLast = (baudCnt == BAUD_W'(CLKS_PER_BIT - 2));
    assign lastReg     = (DumpAddr == ADDR_W'(NUM_REGS - 1));
    assign loadNext    = (state == S_SYNC) || ((byteCnt == 2'd3) && !lastReg);

    // LOAD occupies the final cycle of the preceding stop bit, so bytes run
    // back to back with no idle gap.
    always_comb begin
        stateNxt    = state;
        bitPhaseNxt = bitPhase;
        baudCntNxt  = baudCnt;
        bitCntNxt   = bitCnt;
        byteCntNxt  = byteCnt;
        addrNxt     = DumpAddr;
        shadowNxt   = shadow;
        txNxt       = TX;
        busyNxt     = BUSY;
        doneNxt     = 1'b0;

        case (state)
            S_IDLE: begin
                txNxt   = 1'b1;
                busyNxt = 1'b0;
                addrNxt = '0;
                if (START) begin
                    stateNxt    = S_SYNC;
                    busyNxt     = 1'b1;
                    bitPhaseNxt = B_START;
                    baudCntNxt  = '0;
                    bitCntNxt   = '0;
                    byteCntNxt  = '0;
                    txNxt       = 1'b0;
                end
            end

            S_SYNC, S_SEND: begin
                baudCntNxt = baudLast ? '0 : baudCnt + BAUD_W'(1);
                case (bitPhase)
                    B_START: begin
                        if (baudLast) begin
                            bitPhaseNxt = B_DATA;
                            bitCntNxt   = '0;
                            txNxt       = curByte[0];
                        end
                    end
                    B_DATA: begin
                        if (baudLast) begin
                            if (bitCnt == 3'd7) begin
                                bitPhaseNxt = B_STOP;
                                txNxt       = 1'b1;
                            end else begin
                                bitCntNxt = bitCnt + 3'd1;
                                txNxt     = curByte[bitCnt + 3'd1];
                            end
                        end
                    end
                    B_STOP: begin
                        if (loadNext && baudPreLast) begin
                            stateNxt = S_LOAD;
                            if (state == S_SEND) begin
                                addrNxt = DumpAddr + ADDR_W'(1);
                            end
                        end else if (baudLast) begin
                            if ((state == S_SEND) && (byteCnt != 2'd3)) begin
                                byteCntNxt  = byteCnt + 2'd1;
                                bitPhaseNxt = B_START;
                                txNxt       = 1'b0;
                            end else begin
                                stateNxt = S_FIN;
                                txNxt    = 1'b1;
                            end
                        end
                    end
                    default: bitPhaseNxt = B_START;
                endcase
            end

            S_LOAD: begin
                shadowNxt   = DumpData;
                stateNxt    = S_SEND;
                bitPhaseNxt = B_START;
                baudCntNxt  = '0;
                bitCntNxt   = '0;
                byteCntNxt  = '0;
                txNxt       = 1'b0;
            end

            S_FIN: begin
                stateNxt = S_IDLE;
                busyNxt  = 1'b0;
                doneNxt  = 1'b1;
                addrNxt  = '0;
                txNxt    = 1'b1;
            end

            default: begin
                stateNxt = S_IDLE;
                busyNxt  = 1'b0;
                addrNxt  = '0;
                txNxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            bitPhase <= B_START;
            baudCnt  <= '0;
            bitCnt   <= '0;
            byteCnt  <= '0;
            DumpAddr <= '0;
            shadow   <= '0;
            TX       <= 1'b1;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            state    <= stateNxt;
            bitPhase <= bitPhaseNxt;
            baudCnt  <= baudCntNxt;
            bitCnt   <= bitCntNxt;
            byteCnt  <= byteCntNxt;
            DumpAddr <= addrNxt;
            shadow   <= shadowNxt;
            TX       <= txNxt;
            BUSY     <= busyNxt;
            DONE     <= doneNxt;
        end
    end

endmodule

// File: tb/tb_regfile_dump_uart.sv
// Bench for regfile_dump_uart: timeline reference model checked every cycle,
// an independent UART decoder, and literal checks of the decoded frames.
module tb_regfile_dump_uart;

    localparam int unsigned CPB  = 4;
    localparam int unsigned NR   = 32;
    localparam int          BYTE = 10 * CPB;
    localparam int          LAST = (1 + 4 * NR) * BYTE;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [4:0]  DumpAddr;
    logic [31:0] DumpData;
    logic        TX;
    logic        BUSY;
    logic        DONE;

    logic [31:0] x [NR];
    assign DumpData = x[DumpAddr];

    regfile_dump_uart #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5),
        .NUM_REGS    (NR)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (START),
        .DumpAddr(DumpAddr),
        .DumpData(DumpData),
        .TX      (TX),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: position in the frame timeline, plus register snapshots
    bit          mActive = 1'b0;
    int          mN      = 0;
    logic [31:0] shadowM [NR];

    initial begin
        forever begin
            @(posedge CLK or posedge RESET);
            if (RESET) begin
                mActive = 1'b0;
                mN      = 0;
            end else if (mActive && mN < LAST + 1) begin
                mN++;
            end else if (START) begin
                mActive = 1'b1;
                mN      = 0;
            end else begin
                mActive = 1'b0;
            end
        end
    end

    function automatic logic expTx(input int n);
        int b, byt, pos;
        logic [31:0] w;
        logic [7:0]  v;
        if (n >= LAST) return 1'b1;
        b   = n / CPB;
        byt = b / 10;
        pos = b % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        if (byt == 0) begin
            v = 8'hA5;
        end else begin
            w = shadowM[(byt - 1) / 4];
            v = 8'(w >> (8 * (3 - ((byt - 1) % 4))));
        end
        return v[pos - 1];
    endfunction

    function automatic int expAddr(input int n);
        int r;
        if (n > LAST || n + 1 < BYTE) return 0;
        r = (n + 1 - BYTE) / (4 * BYTE);
        return (r > NR - 1) ? NR - 1 : r;
    endfunction

    int doneCnt   = 0;
    int cyc       = 0;
    int busyRise  = -1;
    int doneAt    = -1;

    // Per-cycle compare against the model
    initial begin
        logic prevBusy;
        int   r;
        prevBusy = 1'b0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (mActive && mN < LAST && mN + 1 >= BYTE && ((mN + 1 - BYTE) % (4 * BYTE)) == 0) begin
                r = (mN + 1 - BYTE) / (4 * BYTE);
                if (r < NR) shadowM[r] = x[r];
            end
            if (!mActive) begin
                chk("idle_tx",   32'(TX),       32'd1);
                chk("idle_busy", 32'(BUSY),     32'd0);
                chk("idle_done", 32'(DONE),     32'd0);
                chk("idle_addr", 32'(DumpAddr), 32'd0);
            end else begin
                chk("tx",   32'(TX),       32'(expTx(mN)));
                chk("busy", 32'(BUSY),     32'(mN <= LAST));
                chk("done", 32'(DONE),     32'(mN == LAST + 1));
                chk("addr", 32'(DumpAddr), 32'(expAddr(mN)));
            end
            if (BUSY && !prevBusy) busyRise = cyc;
            if (DONE) begin
                doneCnt++;
                doneAt = cyc;
            end
            prevBusy = BUSY;
        end
    end

    // Independent UART 8N1 decoder, sampling mid-bit
    logic [7:0] rxq [$];
    initial begin
        bit         act;
        int         c;
        logic [7:0] sh;
        act = 1'b0;
        c   = 0;
        sh  = '0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                act = 1'b0;
            end else if (!act) begin
                if (TX == 1'b0) begin
                    act = 1'b1;
                    c   = 0;
                end
            end else begin
                c++;
                if (c >= 6 && c <= 34 && ((c - 2) % 4) == 0) sh[(c - 6) / 4] = TX;
                if (c == 38) begin
                    chk("stop_bit", 32'(TX), 32'd1);
                    rxq.push_back(sh);
                end
                if (c == 39) act = 1'b0;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic pulseStart();
        START = 1'b1;
        tick(1);
        START = 1'b0;
    endtask

    task automatic waitDone(input int prev, input string nm);
        int g;
        g = 0;
        while (doneCnt == prev && g < 6000) begin
            tick(1);
            g++;
        end
        chk(nm, 32'(doneCnt > prev), 32'd1);
    endtask

    task automatic waitModelN(input int target);
        int g;
        g = 0;
        while (!(mActive && mN == target) && g < 6000) begin
            tick(1);
            g++;
        end
        chk("model_reach", 32'(mActive && mN == target), 32'd1);
    endtask

    initial begin
        int          d0;
        logic [31:0] oldX5;
        int          tgt;
        logic [9:0]  pat;

        RESET = 1'b1;
        START = 1'b0;
        for (int i = 0; i < NR; i++) x[i] = 32'h1000_0000 + 32'(i);
        tick(3);
        RESET = 1'b0;

        // 1: idle after reset
        tick(100);
        chk("t1_tx",   32'(TX),       32'd1);
        chk("t1_busy", 32'(BUSY),     32'd0);
        chk("t1_done", 32'(DONE),     32'd0);
        chk("t1_addr", 32'(DumpAddr), 32'd0);

        // 2: known register contents
        rxq.delete();
        d0 = doneCnt;
        pulseStart();
        waitDone(d0, "t2_done_timeout");
        tick(3);
        chk("t2_done_cnt", 32'(doneCnt - d0), 32'd1);
        chk("t2_latency",  32'(doneAt - busyRise), 32'd5161);
        chk("t2_nbytes",   32'(rxq.size()), 32'd129);
        if (rxq.size() == 129) begin
            chk("t2_sync", 32'(rxq[0]), 32'hA5);
            for (int r = 0; r < NR; r++) begin
                chk("t2_b3", 32'(rxq[1 + 4 * r]), 32'h10);
                chk("t2_b2", 32'(rxq[2 + 4 * r]), 32'h00);
                chk("t2_b1", 32'(rxq[3 + 4 * r]), 32'h00);
                chk("t2_b0", 32'(rxq[4 + 4 * r]), 32'(r));
            end
            chk("t2_last", 32'(rxq[128]), 32'h1F);
        end

        // 3: write to x5 just after its snapshot
        for (int i = 0; i < NR; i++) x[i] = $urandom;
        oldX5 = x[5];
        rxq.delete();
        d0 = doneCnt;
        pulseStart();
        waitModelN(21 * BYTE);
        x[5] = 32'hDEAD_BEEF;
        waitDone(d0, "t3_done_timeout");
        tick(3);
        chk("t3_nbytes", 32'(rxq.size()), 32'd129);
        if (rxq.size() == 129) begin
            chk("t3_old3", 32'(rxq[21]), 32'(8'(oldX5 >> 24)));
            chk("t3_old2", 32'(rxq[22]), 32'(8'(oldX5 >> 16)));
            chk("t3_old1", 32'(rxq[23]), 32'(8'(oldX5 >> 8)));
            chk("t3_old0", 32'(rxq[24]), 32'(8'(oldX5)));
        end
        rxq.delete();
        d0 = doneCnt;
        pulseStart();
        waitDone(d0, "t3b_done_timeout");
        tick(3);
        chk("t3b_nbytes", 32'(rxq.size()), 32'd129);
        if (rxq.size() == 129) begin
            chk("t3b_de", 32'(rxq[21]), 32'hDE);
            chk("t3b_ad", 32'(rxq[22]), 32'hAD);
            chk("t3b_be", 32'(rxq[23]), 32'hBE);
            chk("t3b_ef", 32'(rxq[24]), 32'hEF);
        end

        // 4: random START pulses and register writes during a frame
        rxq.delete();
        d0 = doneCnt;
        START = 1'b1;
        tick(1);
        while (mActive && mN < 5000) begin
            START = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) x[$urandom_range(0, NR - 1)] = $urandom;
            tick(1);
        end
        START = 1'b0;
        waitDone(d0, "t4_done_timeout");
        tick(50);
        chk("t4_done_cnt", 32'(doneCnt - d0), 32'd1);
        chk("t4_nbytes",   32'(rxq.size()), 32'd129);
        chk("t4_tx_idle",  32'(TX), 32'd1);
        chk("t4_busy",     32'(BUSY), 32'd0);

        // 5: reset during a data bit of r12, then a full frame
        d0 = doneCnt;
        pulseStart();
        tgt = 49 * BYTE + BYTE * int'($urandom_range(0, 3)) + CPB + int'($urandom_range(0, 31));
        waitModelN(tgt);
        RESET = 1'b1;
        #1;
        chk("t5_tx_now",   32'(TX),       32'd1);
        chk("t5_busy_now", 32'(BUSY),     32'd0);
        chk("t5_addr_now", 32'(DumpAddr), 32'd0);
        tick(2);
        RESET = 1'b0;
        tick(20);
        chk("t5_no_done", 32'(doneCnt - d0), 32'd0);
        rxq.delete();
        pulseStart();
        waitDone(d0, "t5_done_timeout");
        tick(3);
        chk("t5_nbytes", 32'(rxq.size()), 32'd129);
        if (rxq.size() == 129) begin
            chk("t5_sync", 32'(rxq[0]), 32'hA5);
            chk("t5_r0b3", 32'(rxq[1]), 32'(8'(x[0] >> 24)));
            chk("t5_r0b0", 32'(rxq[4]), 32'(8'(x[0])));
        end

        // 6: bit timing of the sync byte, LSB first with start/stop framing
        pat = 10'b1101001010;
        d0  = doneCnt;
        START = 1'b1;
        @(posedge CLK);
        #2;
        START = 1'b0;
        for (int k = 0; k < BYTE; k++) begin
            @(negedge CLK);
            chk("t6_bit", 32'(TX), 32'(pat[k / CPB]));
            if (k == BYTE - 1) tick(0);
        end
        tick(1);
        waitDone(d0, "t6_done_timeout");

        // 7: START held high across FIN into IDLE starts a second frame
        tick(5);
        rxq.delete();
        d0 = doneCnt;
        START = 1'b1;
        waitDone(d0, "t7_done_timeout");
        tick(1);
        START = 1'b0;
        chk("t7_restart_busy", 32'(BUSY), 32'd1);
        waitDone(d0 + 1, "t7b_done_timeout");
        tick(10);
        chk("t7_done_cnt", 32'(doneCnt - d0), 32'd2);
        chk("t7_nbytes",   32'(rxq.size()), 32'd258);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
